// File: rtl/rom_access_arbiter.sv
// Shared ROM port arbiter: two lookup requesters plus a background scanner.
// Round-robin between A and B, with an anti-starvation slot for the scanner.
module rom_access_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_a,
    input  logic [2:0]  addr_a,
    input  logic        req_b,
    input  logic [2:0]  addr_b,
    input  logic        scan_en,
    input  logic [15:0] rom_data,
    output logic [2:0]  rom_addr,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        rvalid_a,
    output logic        rvalid_b,
    output logic [15:0] rdata,
    output logic [15:0] scan_data,
    output logic [2:0]  scan_addr,
    output logic        scan_valid
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       last_b;
    logic       force_scan;
    logic       pick_a;
    logic       pick_b;
    logic       gnt_s;

    // last_b set means B won most recently, so A wins the next contention
    always_comb begin
        force_scan = scan_en && (starve_cnt == LIMIT);
        pick_a     = req_a && (!req_b || last_b);
        pick_b     = req_b && !pick_a;
        gnt_a      = rst_n && !force_scan && pick_a;
        gnt_b      = rst_n && !force_scan && pick_b;
        gnt_s      = rst_n && scan_en && !gnt_a && !gnt_b;
    end

    always_comb begin
        rom_addr = scan_addr;
        unique case (1'b1)
            gnt_a:   rom_addr = addr_a;
            gnt_b:   rom_addr = addr_b;
            default: rom_addr = scan_addr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
            last_b     <= 1'b1;
            scan_addr  <= 3'd0;
            rdata      <= 16'd0;
            scan_data  <= 16'd0;
            rvalid_a   <= 1'b0;
            rvalid_b   <= 1'b0;
            scan_valid <= 1'b0;
        end else begin
            rvalid_a   <= gnt_a;
            rvalid_b   <= gnt_b;
            scan_valid <= gnt_s;
            if (gnt_a || gnt_b) begin
                rdata  <= rom_data;
                last_b <= gnt_b;
            end
            if (gnt_s) begin
                scan_data <= rom_data;
                scan_addr <= scan_addr + 3'd1;
            end
            if (!scan_en || gnt_s)
                starve_cnt <= 4'd0;
            else if (starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: doc/rom_access_arbiter.md
ROM_ACCESS_ARBITER -- requirements
Module: rom_access_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8, sets consecutive scanner-denied cycles before a forced scanner slot; legal range 1..15.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_a  input  1  requester A lookup request; held high until gnt_a.
REQ-005 addr_a  input  3  requester A ROM address; stable while req_a high.
REQ-006 req_b  input  1  requester B lookup request; held high until gnt_b.
REQ-007 addr_b  input  3  requester B ROM address; stable while req_b high.
REQ-008 scan_en  input  1  enables background scanner stepping through addresses 0..7.
REQ-009 rom_data  input  16  combinational ROM output for rom_addr.
REQ-010 rom_addr  output  3  address driven to the shared ROM.
REQ-011 gnt_a / gnt_b  output  1 each  combinational grant, same cycle as the selected request.
REQ-012 rvalid_a / rvalid_b  output  1 each  one-cycle pulse; rdata valid for that requester.
REQ-013 rdata  output  16  registered ROM word for A/B lookups.
REQ-014 scan_data  output  16  registered ROM word from last scanner slot.
REQ-015 scan_addr  output  3  scanner address counter (address of the next scanner slot).
REQ-016 scan_valid  output  1  one-cycle pulse; scan_data updated.

Function
REQ-017 Block SHALL grant exactly one ROM slot per cycle to at most one of: A, B, scanner.
REQ-018 Priority per cycle SHALL be: forced scanner slot > A/B round-robin > scanner > idle.
REQ-019 A alone requesting SHALL get gnt_a; B alone SHALL get gnt_b.
REQ-020 A and B both requesting SHALL grant the one not granted most recently; last-granted register SHALL reset to B (A wins first contention).
REQ-021 Last-granted register SHALL update only on cycles A or B is granted.
REQ-022 Scanner SHALL be granted when scan_en=1 and neither A nor B is granted.
REQ-023 rom_addr SHALL be addr_a, addr_b or scan_addr per grant; SHALL be scan_addr when idle.
REQ-024 Latency: on the edge ending a grant cycle, rom_data SHALL be captured into rdata (A/B) or scan_data (scanner); rvalid_x / scan_valid SHALL be high exactly the following cycle.
REQ-025 rdata and scan_data SHALL hold their values when not written.
REQ-026 scan_addr SHALL increment by 1 modulo 8 (7 -> 0) only on scanner-granted cycles; SHALL hold when scan_en=0.
REQ-027 Starvation counter (4 bit) SHALL increment on each cycle scan_en=1 and scanner not granted, saturating at STARVE_LIMIT.
REQ-028 When counter equals STARVE_LIMIT and scan_en=1, scanner SHALL be granted that cycle, gnt_a and gnt_b SHALL be 0, counter SHALL clear to 0; pending A/B requests SHALL wait.
REQ-029 Counter SHALL clear on any scanner grant and on any cycle scan_en=0.
REQ-030 A forced scanner slot SHALL NOT change the last-granted register.
REQ-031 A request deasserted without grant SHALL be dropped without side effects.

Reset
REQ-032 While rst_n=0 at an edge: scan_addr=0, starvation counter=0, last-granted=B, rdata=0, scan_data=0, rvalid_a=rvalid_b=scan_valid=0.
REQ-033 gnt_a and gnt_b SHALL be 0 during reset cycles regardless of requests; reset mid-grant SHALL suppress the pending rvalid.

Verification
REQ-034 req_a=1 addr_a=5, req_b=0, scan_en=0 -> gnt_a=1, rom_addr=5; next cycle rvalid_a=1, rdata=ROM[5].
REQ-035 req_a=req_b=1 held 4 cycles after reset -> grants A,B,A,B; rvalid pulses follow each by one cycle.
REQ-036 scan_en=1 alone for 9 cycles from reset -> scan_valid every cycle, scan_data=ROM[0..7],ROM[0]; scan_addr wraps 7->0.
REQ-037 scan_en=1, req_a held continuously, STARVE_LIMIT=8 -> 8 A grants, 9th cycle scanner granted with gnt_a=0, then A resumes.
REQ-038 rst_n=0 asserted in cycle with gnt_b=1 -> next cycle rvalid_b=0, rdata=0, scan_addr=0.
